// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if: handshake bundle between NCH producers, the mux and one consumer.
//   in_data   NCH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid  NCH        per-channel valid
//   in_ready  NCH        per-channel accept (driven by the mux)
//   mode      1          0 = fixed select, 1 = round-robin
//   sel       SELW       channel index used in fixed mode
//   out_data  WIDTH      registered output data (driven by the mux)
//   out_valid 1          out_data is valid (driven by the mux)
//   out_ready 1          consumer accepts out_data
//   out_ch    SELW       source channel of out_data (driven by the mux)
// modport slave is the mux view; modport master is the producer/consumer view.
interface stream_mux_rr_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
);
    localparam int SELW = $clog2(NCH);
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SELW-1:0]      out_ch;
    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );
    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );
endinterface

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel stream mux, fixed-select or round-robin, one registered output stage.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    stream_mux_rr_if.slave (inputs, grants and registered output)
module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    stream_mux_rr_if.slave bus
);
    localparam int SELW = $clog2(NCH);
    logic [WIDTH-1:0] chan [NCH];
    logic [SELW-1:0]  ptr, gnt, idx;
    logic             has_gnt, slot_free, xfer;
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign chan[i] = bus.in_data[i*WIDTH +: WIDTH];
    end
    always_comb begin
        gnt = '0;
        idx = '0;
        has_gnt = 1'b0;
        if (bus.mode) begin
            // first valid channel at or after ptr, wrapping modulo NCH
            for (int k = 0; k < NCH; k++) begin
                idx = SELW'((int'(ptr) + k) % NCH);
                if (!has_gnt && bus.in_valid[idx]) begin
                    has_gnt = 1'b1;
                    gnt = idx;
                end
            end
        end else begin
            // loop form also rejects sel values >= NCH when NCH is not a power of two
            for (int k = 0; k < NCH; k++) begin
                if (bus.sel == SELW'(k) && bus.in_valid[k]) begin
                    has_gnt = 1'b1;
                    gnt = SELW'(k);
                end
            end
        end
        // rst_n gate keeps every in_ready low while reset is held
        slot_free = rst_n && (!bus.out_valid || bus.out_ready);
        xfer = has_gnt && slot_free;
        bus.in_ready = xfer ? NCH'(1) << gnt : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
            bus.out_ch <= '0;
            ptr <= '0;
        end else if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data <= chan[gnt];
            bus.out_ch <= gnt;
            if (bus.mode) ptr <= (gnt == SELW'(NCH-1)) ? '0 : gnt + 1'b1;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule
